// File: rtl/mc_control_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mc_defs (package)
//  Description : Shared opcode/func, ALU function, immediate-mode and state
//                encodings for the multi-cycle controller, ALU and DECSTAGE.
//  Revision    : 1.0  initial release
// ============================================================================
package mc_defs;

  // Primary opcodes (Instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_LI    = 6'b111000;
  localparam logic [5:0] OP_LUI   = 6'b111001;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_NANDI = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_B     = 6'b111111;
  localparam logic [5:0] OP_BEQ   = 6'b000000;
  localparam logic [5:0] OP_BNE   = 6'b000001;
  localparam logic [5:0] OP_LB    = 6'b000011;
  localparam logic [5:0] OP_SB    = 6'b000111;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_SW    = 6'b011111;

  // Legal R-type func windows (Instr[5:0]); ALU_func is func[3:0]
  localparam logic [5:0] FUNC_A_LO = 6'b110000;
  localparam logic [5:0] FUNC_A_HI = 6'b110101;
  localparam logic [5:0] FUNC_B_LO = 6'b111000;
  localparam logic [5:0] FUNC_B_HI = 6'b111010;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_NAND = 4'b0101;

  // Immediate extension modes
  localparam logic [1:0] IMM_SEXT     = 2'b00;
  localparam logic [1:0] IMM_ZFILL    = 2'b01;
  localparam logic [1:0] IMM_HI16     = 2'b10;
  localparam logic [1:0] IMM_SEXT_SH2 = 2'b11;

  // Controller states
  typedef enum logic [3:0] {
    ST_IFETCH   = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_EXEC_I   = 4'd3,
    ST_EXEC_BR  = 4'd4,
    ST_MEM_ADDR = 4'd5,
    ST_MEM_RD   = 4'd6,
    ST_MEM_WR   = 4'd7,
    ST_WB_ALU   = 4'd8,
    ST_WB_MEM   = 4'd9
  } state_t;

  // Instruction classes produced by the opcode decoder
  typedef enum logic [2:0] {
    IC_RTYPE   = 3'd0,
    IC_ITYPE   = 3'd1,
    IC_BRANCH  = 3'd2,
    IC_MEM     = 3'd3,
    IC_ILLEGAL = 3'd4
  } iclass_t;

  // Branch condition kinds
  typedef enum logic [1:0] {
    BR_ALWAYS = 2'd0,
    BR_EQ     = 2'd1,
    BR_NE     = 2'd2
  } brkind_t;

  // Control output bundle
  typedef struct packed {
    logic       pc_sel;
    logic       pc_ld;
    logic       ir_ld;
    logic       rf_we;
    logic       rf_wsel;
    logic       rf_bsel;
    logic [1:0] imm_ext;
    logic       alu_bin_sel;
    logic [3:0] alu_func;
    logic       mem_we;
    logic       byte_op;
    logic       illegal;
  } ctrl_t;

  // True when func lies in one of the two implemented R-type windows
  function automatic logic func_legal(input logic [5:0] f);
    return ((f >= FUNC_A_LO) && (f <= FUNC_A_HI)) ||
           ((f >= FUNC_B_LO) && (f <= FUNC_B_HI));
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_control_opdecode.sv
`default_nettype none
// ============================================================================
//  Module      : mc_opdecode
//  Description : Combinational opcode/func decoder: instruction class,
//                memory/branch qualifiers and I-type ALU/immediate constants.
//  Revision    : 1.0  initial release
// ============================================================================
module mc_opdecode
  import mc_defs::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] func_i,
  output iclass_t    iclass_o,
  output logic       is_store_o,
  output logic       is_byte_o,
  output logic       func_ok_o,
  output brkind_t    brkind_o,
  output logic [3:0] ialu_func_o,
  output logic [1:0] iimm_o
);

  // Classify the opcode and look up per-instruction constants
  always_comb begin
    iclass_o    = IC_ILLEGAL;
    is_store_o  = 1'b0;
    is_byte_o   = 1'b0;
    brkind_o    = BR_ALWAYS;
    ialu_func_o = ALU_ADD;
    iimm_o      = IMM_SEXT;
    func_ok_o   = func_legal(func_i);
    case (opcode_i)
      OP_RTYPE: iclass_o = IC_RTYPE;
      OP_LI: begin
        iclass_o = IC_ITYPE;
      end
      OP_LUI: begin
        iclass_o = IC_ITYPE;
        iimm_o   = IMM_HI16;
      end
      OP_ADDI: begin
        iclass_o = IC_ITYPE;
      end
      OP_NANDI: begin
        iclass_o    = IC_ITYPE;
        ialu_func_o = ALU_NAND;
        iimm_o      = IMM_ZFILL;
      end
      OP_ORI: begin
        iclass_o    = IC_ITYPE;
        ialu_func_o = ALU_OR;
        iimm_o      = IMM_ZFILL;
      end
      OP_B: begin
        iclass_o = IC_BRANCH;
        brkind_o = BR_ALWAYS;
      end
      OP_BEQ: begin
        iclass_o = IC_BRANCH;
        brkind_o = BR_EQ;
      end
      OP_BNE: begin
        iclass_o = IC_BRANCH;
        brkind_o = BR_NE;
      end
      OP_LB: begin
        iclass_o  = IC_MEM;
        is_byte_o = 1'b1;
      end
      OP_SB: begin
        iclass_o   = IC_MEM;
        is_byte_o  = 1'b1;
        is_store_o = 1'b1;
      end
      OP_LW: iclass_o = IC_MEM;
      OP_SW: begin
        iclass_o   = IC_MEM;
        is_store_o = 1'b1;
      end
      default: iclass_o = IC_ILLEGAL;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
//  Module      : mc_control
//  Description : Multi-cycle processor control FSM. Outputs are decoded from
//                the registered state and latched opcode/func; only the
//                EXEC_BR PC load follows Zero, and Reset blanks all outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module mc_control
  import mc_defs::*;
(
  input  logic        Clk_i,
  input  logic        Reset_i,
  input  logic [31:0] Instr_i,
  input  logic        Zero_i,
  output logic        PC_sel_o,
  output logic        PC_LdEn_o,
  output logic        IR_LdEn_o,
  output logic        RF_WrEn_o,
  output logic        RF_WrData_sel_o,
  output logic        RF_B_sel_o,
  output logic [1:0]  ImmExt_o,
  output logic        ALU_Bin_sel_o,
  output logic [3:0]  ALU_func_o,
  output logic        MEM_WrEn_o,
  output logic        Byte_op_o,
  output logic        Illegal_op_o
);

  state_t     state_q, state_d;
  logic [5:0] opc_q, func_q;

  logic [5:0] dec_opcode, dec_func;
  iclass_t    iclass;
  brkind_t    brkind;
  logic       is_store, is_byte, func_ok;
  logic [3:0] ialu_func;
  logic [1:0] iimm;
  ctrl_t      ctrl_raw, ctrl_out;

  // Operand fields of Instr are consumed by the datapath, not here
  logic instr_unused;
  assign instr_unused = ^Instr_i[25:6];

  // In DECODE the IR is already stable, so dispatch straight from Instr;
  // later states use the copy latched at the end of DECODE.
  assign dec_opcode = (state_q == ST_DECODE) ? Instr_i[31:26] : opc_q;
  assign dec_func   = (state_q == ST_DECODE) ? Instr_i[5:0]   : func_q;

  mc_opdecode u_opdecode (
    .opcode_i    (dec_opcode),
    .func_i      (dec_func),
    .iclass_o    (iclass),
    .is_store_o  (is_store),
    .is_byte_o   (is_byte),
    .func_ok_o   (func_ok),
    .brkind_o    (brkind),
    .ialu_func_o (ialu_func),
    .iimm_o      (iimm)
  );

  // Next-state selection
  always_comb begin
    state_d = ST_IFETCH;
    case (state_q)
      ST_IFETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        case (iclass)
          IC_RTYPE:  state_d = ST_EXEC_R;
          IC_ITYPE:  state_d = ST_EXEC_I;
          IC_BRANCH: state_d = ST_EXEC_BR;
          IC_MEM:    state_d = ST_MEM_ADDR;
          default:   state_d = ST_IFETCH;
        endcase
      end
      ST_EXEC_R:   state_d = func_ok ? ST_WB_ALU : ST_IFETCH;
      ST_EXEC_I:   state_d = ST_WB_ALU;
      ST_MEM_ADDR: state_d = is_store ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD:   state_d = ST_WB_MEM;
      default:     state_d = ST_IFETCH;
    endcase
  end

  // State register and opcode/func latch; reset overrides any transition
  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      state_q <= ST_IFETCH;
      opc_q   <= '0;
      func_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) begin
        opc_q  <= Instr_i[31:26];
        func_q <= Instr_i[5:0];
      end
    end
  end

  // Moore output decode per state (branch PC load is the one Zero-dependent term)
  always_comb begin
    ctrl_raw = '0;
    case (state_q)
      ST_IFETCH: begin
        ctrl_raw.ir_ld = 1'b1;
        ctrl_raw.pc_ld = 1'b1;
      end
      ST_DECODE: ctrl_raw.illegal = (iclass == IC_ILLEGAL);
      ST_EXEC_R: begin
        if (func_ok) ctrl_raw.alu_func = func_q[3:0];
        else         ctrl_raw.illegal  = 1'b1;
      end
      ST_EXEC_I: begin
        ctrl_raw.alu_bin_sel = 1'b1;
        ctrl_raw.alu_func    = ialu_func;
        ctrl_raw.imm_ext     = iimm;
      end
      ST_EXEC_BR: begin
        ctrl_raw.rf_bsel  = 1'b1;
        ctrl_raw.alu_func = ALU_SUB;
        ctrl_raw.imm_ext  = IMM_SEXT_SH2;
        ctrl_raw.pc_sel   = 1'b1;
        case (brkind)
          BR_EQ:   ctrl_raw.pc_ld = Zero_i;
          BR_NE:   ctrl_raw.pc_ld = ~Zero_i;
          default: ctrl_raw.pc_ld = 1'b1;
        endcase
      end
      // Address operands stay selected through the access cycle
      ST_MEM_ADDR, ST_MEM_RD, ST_MEM_WR: begin
        ctrl_raw.alu_bin_sel = 1'b1;
        ctrl_raw.alu_func    = ALU_ADD;
        ctrl_raw.imm_ext     = IMM_SEXT;
        ctrl_raw.rf_bsel     = 1'b1;
        ctrl_raw.byte_op     = is_byte;
        ctrl_raw.mem_we      = (state_q == ST_MEM_WR);
      end
      ST_WB_ALU: ctrl_raw.rf_we = 1'b1;
      ST_WB_MEM: begin
        ctrl_raw.rf_we   = 1'b1;
        ctrl_raw.rf_wsel = 1'b1;
        ctrl_raw.byte_op = is_byte;
      end
      default: ctrl_raw = '0;
    endcase
  end

  // Reset blanks every output, including the IFETCH strobes
  assign ctrl_out = Reset_i ? '0 : ctrl_raw;

  assign PC_sel_o        = ctrl_out.pc_sel;
  assign PC_LdEn_o       = ctrl_out.pc_ld;
  assign IR_LdEn_o       = ctrl_out.ir_ld;
  assign RF_WrEn_o       = ctrl_out.rf_we;
  assign RF_WrData_sel_o = ctrl_out.rf_wsel;
  assign RF_B_sel_o      = ctrl_out.rf_bsel;
  assign ImmExt_o        = ctrl_out.imm_ext;
  assign ALU_Bin_sel_o   = ctrl_out.alu_bin_sel;
  assign ALU_func_o      = ctrl_out.alu_func;
  assign MEM_WrEn_o      = ctrl_out.mem_we;
  assign Byte_op_o       = ctrl_out.byte_op;
  assign Illegal_op_o    = ctrl_out.illegal;

endmodule
`default_nettype wire
